oam_dma: RTL

Object-attribute DMA engine feeding the 80-word × 16-bit sprite attribute RAM. A CPU write to the DMA register pulses `start` with a source page. The block then copies 160 bytes from that page through the system memory port, one byte per machine cycle. It packs byte pairs into 16-bit words and writes them into the attribute RAM's write port, asserting `busy` so the bus arbiter can lock the CPU out of non-HRAM memory.

---
 rtl/dma_pkg.sv | 17 +
 rtl/oam_dma.sv | 106 ++++++++++
 2 files changed

// File: rtl/dma_pkg.sv
// Shared constants, state encoding and page mapping for the OAM DMA engine.
package dma_pkg;

  localparam int unsigned OAM_BYTES = 160;
  localparam int unsigned OAM_WORDS = 80;

  localparam logic [7:0] ECHO_BASE   = 8'hE0;
  localparam logic [7:0] ECHO_OFFSET = 8'h20;

  typedef enum logic [1:0] {IDLE, DELAY, XFER, DRAIN} dma_state_t;

  // Pages in the echo window alias work RAM 0x20 pages lower.
  function automatic logic [7:0] map_page(input logic [7:0] page);
    return (page >= ECHO_BASE) ? page - ECHO_OFFSET : page;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// Sprite-attribute DMA: streams a 160-byte source page into the 80x16 OAM,
// packing little-endian byte pairs into words.
module oam_dma
  import dma_pkg::*;
#(
  parameter int unsigned BYTES = OAM_BYTES,
  parameter int unsigned WORDS = OAM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        start,
  input  logic [7:0]  src_page,
  output logic [15:0] src_addr,
  output logic        src_rd,
  input  logic [7:0]  src_data,
  output logic [6:0]  oam_addr,
  output logic [15:0] oam_d,
  output logic        oam_write,
  output logic        busy
);

  localparam logic [7:0] LAST_IDX = 8'(BYTES - 1);

  dma_state_t state;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] lo;
  logic       s1_v, s2_v;
  logic [7:0] s1_idx, s2_idx;

  logic done;
  logic abort;

  // The final drain tick completes normally even if a new start lands on it.
  assign done  = (state == DRAIN) && !s1_v;
  assign abort = start && (state != IDLE) && !done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      page      <= '0;
      idx       <= '0;
      lo        <= '0;
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      s1_idx    <= '0;
      s2_idx    <= '0;
      src_addr  <= '0;
      src_rd    <= 1'b0;
      oam_addr  <= '0;
      oam_d     <= '0;
      oam_write <= 1'b0;
      busy      <= 1'b0;
    end else begin
      oam_write <= 1'b0;
      if (ce) begin
        // Stage 2 holds the byte whose data is on src_data this tick.
        if (s2_v && !abort) begin
          if (!s2_idx[0]) begin
            lo <= src_data;
          end else if (s2_idx[7:1] < 7'(WORDS)) begin
            oam_addr  <= s2_idx[7:1];
            oam_d     <= {src_data, lo};
            oam_write <= 1'b1;
          end
        end

        if (start) begin
          page   <= map_page(src_page);
          idx    <= '0;
          s1_v   <= 1'b0;
          s2_v   <= 1'b0;
          lo     <= '0;
          src_rd <= 1'b0;
          busy   <= 1'b1;
          state  <= DELAY;
        end else begin
          s2_v   <= s1_v;
          s2_idx <= s1_idx;
          s1_v   <= 1'b0;
          unique case (state)
            IDLE: ;
            // Byte 0's read launches on the delay tick so byte n's read lands on T(n+1).
            DELAY, XFER: begin
              src_addr <= {page, idx};
              src_rd   <= 1'b1;
              s1_v     <= 1'b1;
              s1_idx   <= idx;
              idx      <= idx + 8'd1;
              state    <= (idx == LAST_IDX) ? DRAIN : XFER;
            end
            DRAIN: begin
              src_rd <= 1'b0;
              if (!s1_v) begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          endcase
        end
      end
    end
  end

endmodule
